// File: rtl/demux_pkg.sv
// demux_pkg: shared state type and default width for the 1:2 packet demux
package demux_pkg;
    typedef enum logic [1:0] {IDLE, ROUTE0, ROUTE1} state_t;
    localparam int DEFAULT_WIDTH = 8;
endpackage

// File: rtl/stream_reg.sv
// stream_reg: one-entry valid/ready output register
module stream_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_last,
    output logic             valid,
    input  logic             ready,
    output logic [WIDTH-1:0] data,
    output logic             last
);
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
            last  <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            last  <= load_last;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end
endmodule

// File: rtl/demux1_2.sv
// demux1_2: packet demux routing each packet to one of two registered output ports
module demux1_2
    import demux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic             in_sel,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_last,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_last,
    output logic [7:0]       pkt_cnt0,
    output logic [7:0]       pkt_cnt1
);
    state_t state, state_nx;
    logic   tgt, fire, ld0, ld1;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            pkt_cnt0 <= '0;
            pkt_cnt1 <= '0;
        end else begin
            state    <= state_nx;
            pkt_cnt0 <= pkt_cnt0 + 8'(out0_valid && out0_ready && out0_last);
            pkt_cnt1 <= pkt_cnt1 + 8'(out1_valid && out1_ready && out1_last);
        end
    end
    // in_sel only matters on a packet head; mid-packet the state holds the lock
    always_comb begin
        tgt      = state == ROUTE1 ? 1'b1 : state == ROUTE0 ? 1'b0 : in_sel;
        in_ready = rst_n && (tgt ? (!out1_valid || out1_ready) : (!out0_valid || out0_ready));
        fire     = in_valid && in_ready;
        ld0      = fire && !tgt;
        ld1      = fire && tgt;
        state_nx = !fire ? state : in_last ? IDLE : tgt ? ROUTE1 : ROUTE0;
    end
    stream_reg #(.WIDTH(WIDTH)) u_reg0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (ld0),
        .load_data (in_data),
        .load_last (in_last),
        .valid     (out0_valid),
        .ready     (out0_ready),
        .data      (out0_data),
        .last      (out0_last)
    );
    stream_reg #(.WIDTH(WIDTH)) u_reg1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (ld1),
        .load_data (in_data),
        .load_last (in_last),
        .valid     (out1_valid),
        .ready     (out1_ready),
        .data      (out1_data),
        .last      (out1_last)
    );
endmodule

// File: tb/tb_demux1_2.sv
// tb_demux1_2: directed and random stimulus checked against a queue-based packet model
module tb_demux1_2;
    logic       clk, rst_n, in_valid, in_ready, in_last, in_sel;
    logic [7:0] in_data, out0_data, out1_data, pkt_cnt0, pkt_cnt1;
    logic       out0_valid, out0_ready, out0_last, out1_valid, out1_ready, out1_last;
    int         n_tests, n_fail;
    logic [8:0] q0[$], q1[$];
    int         lock, c0, c1;
    logic [7:0] held;
    demux1_2 #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_sel     (in_sel),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_data  (out0_data),
        .out0_last  (out0_last),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data),
        .out1_last  (out1_last),
        .pkt_cnt0   (pkt_cnt0),
        .pkt_cnt1   (pkt_cnt1)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask
    // one clock: drive, compare against the model, then advance the model across the edge
    task automatic cycle(input logic rs, input logic v, input logic [7:0] d,
                         input logic l, input logic s, input logic r0, input logic r1);
        int  t;
        logic exp_rdy;
        @(negedge clk);
        rst_n = rs; in_valid = v; in_data = d; in_last = l; in_sel = s;
        out0_ready = r0; out1_ready = r1;
        #1;
        t = lock < 0 ? int'(s) : lock;
        exp_rdy = rs && (t == 0 ? (q0.size() == 0 || r0) : (q1.size() == 0 || r1));
        chk("in_ready", in_ready, exp_rdy);
        chk("out0_valid", out0_valid, q0.size() != 0);
        chk("out1_valid", out1_valid, q1.size() != 0);
        if (q0.size() != 0) chk("out0_beat", {out0_last, out0_data}, q0[0]);
        if (q1.size() != 0) chk("out1_beat", {out1_last, out1_data}, q1[0]);
        chk("pkt_cnt0", pkt_cnt0, c0);
        chk("pkt_cnt1", pkt_cnt1, c1);
        @(posedge clk);
        if (!rs) begin
            q0.delete(); q1.delete(); lock = -1; c0 = 0; c1 = 0;
        end else begin
            if (q0.size() != 0 && r0) begin
                if (q0[0][8]) c0 = (c0 + 1) % 256;
                void'(q0.pop_front());
            end
            if (q1.size() != 0 && r1) begin
                if (q1[0][8]) c1 = (c1 + 1) % 256;
                void'(q1.pop_front());
            end
            if (v && exp_rdy) begin
                if (t == 0) q0.push_back({l, d}); else q1.push_back({l, d});
                lock = l ? -1 : t;
            end
        end
    endtask
    task automatic do_reset();
        cycle(0, 0, 8'h00, 0, 0, 1, 1);
        cycle(0, 1, 8'hFF, 1, 1, 1, 1);
    endtask
    initial begin
        n_tests = 0; n_fail = 0; lock = -1; c0 = 0; c1 = 0;
        rst_n = 0; in_valid = 0; in_data = 0; in_last = 0; in_sel = 0;
        out0_ready = 0; out1_ready = 0;
        do_reset();
        #1;
        chk("rst_beat0", {out0_last, out0_data}, 9'h000);
        chk("rst_beat1", {out1_last, out1_data}, 9'h000);
        // single beat to port 1
        cycle(1, 1, 8'hA5, 1, 1, 1, 1);
        cycle(1, 0, 8'h00, 0, 0, 1, 1);
        cycle(1, 0, 8'h00, 0, 0, 1, 1);
        chk("single_cnt1", pkt_cnt1, 8'd1);
        // locked packet: later in_sel values must be ignored
        cycle(1, 1, 8'h11, 0, 0, 1, 1);
        cycle(1, 1, 8'h22, 0, 1, 1, 1);
        cycle(1, 1, 8'h33, 1, 1, 1, 1);
        cycle(1, 1, 8'h44, 1, 1, 1, 1);
        cycle(1, 0, 8'h00, 0, 0, 1, 1);
        cycle(1, 0, 8'h00, 0, 0, 1, 1);
        chk("locked_cnt0", pkt_cnt0, 8'd1);
        // backpressure on port 0 with a beat held
        cycle(1, 1, 8'h5A, 0, 0, 0, 1);
        held = 8'h5A;
        for (int i = 0; i < 4; i++) begin
            cycle(1, 1, 8'h60 + 8'(i), 0, 1, 0, 1);
            chk("bp_hold", out0_data, held);
        end
        // independent ports: port 0 still stalled mid-packet, so finish it first
        cycle(1, 1, 8'h66, 1, 0, 1, 1);
        cycle(1, 0, 8'h00, 0, 0, 0, 1);
        cycle(1, 1, 8'h77, 1, 1, 0, 1);
        cycle(1, 0, 8'h00, 0, 0, 0, 1);
        chk("indep_beat1", {out1_last, out1_data}, 9'h177);
        cycle(1, 0, 8'h00, 0, 0, 1, 1);
        cycle(1, 0, 8'h00, 0, 0, 1, 1);
        // counter wrap
        do_reset();
        for (int i = 0; i < 256; i++) cycle(1, 1, 8'(i), 1, 0, 1, 1);
        cycle(1, 0, 8'h00, 0, 0, 1, 1);
        #1;
        chk("wrap_cnt0", pkt_cnt0, 8'd0);
        // reset mid-packet then a fresh head routed by its own sel
        cycle(1, 1, 8'hB1, 0, 1, 0, 0);
        cycle(1, 1, 8'hB2, 0, 0, 0, 0);
        do_reset();
        cycle(1, 1, 8'hC3, 1, 0, 1, 1);
        #1;
        chk("post_rst_valid0", out0_valid, 1'b1);
        chk("post_rst_valid1", out1_valid, 1'b0);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(199) != 0, $urandom_range(3) != 0, 8'($urandom),
                  $urandom_range(2) == 0, 1'($urandom), $urandom_range(9) < 7,
                  $urandom_range(9) < 7);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
